// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 controller, message expansion and compression.
package sha256_pkg;

   // State codes seen by the ME and compression datapath on fsm_state_out.
   localparam logic [2:0] IDLE   = 3'b000;
   localparam logic [2:0] INIT   = 3'b001;
   localparam logic [2:0] LOAD   = 3'b010;
   localparam logic [2:0] ROUND  = 3'b011;
   localparam logic [2:0] UPDATE = 3'b100;
   localparam logic [2:0] DONE   = 3'b101;

   localparam int unsigned BLOCK_WORDS = 16;
   localparam int unsigned ROUNDS      = 64;

   typedef enum logic [2:0] {
      StIdle   = IDLE,
      StInit   = INIT,
      StLoad   = LOAD,
      StRound  = ROUND,
      StUpdate = UPDATE,
      StDone   = DONE
   } state_e;

endpackage

// File: rtl/sha256_core_ctrl.sv
// Block sequencer for one SHA-256 core: IV load, 16-word message load, 64 rounds,
// hash update and digest handshake.
module sha256_core_ctrl
   import sha256_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_in,
   input  logic                  new_msg_in,
   input  logic                  last_blk_in,
   input  logic                  clear_in,
   input  logic                  msg_valid_in,
   input  logic [DATA_WIDTH-1:0] msg_word_in,
   output logic                  msg_ready_out,
   output logic [2:0]            fsm_state_out,
   output logic [CNT_WIDTH-1:0]  count_out,
   output logic [DATA_WIDTH-1:0] word_out,
   output logic                  hash_init_out,
   output logic                  round_en_out,
   output logic                  hash_update_out,
   output logic                  block_done_out,
   output logic                  digest_valid_out,
   input  logic                  digest_ready_in,
   output logic                  busy_out
);

   localparam logic [CNT_WIDTH-1:0] LastWord  = CNT_WIDTH'(BLOCK_WORDS - 1);
   localparam logic [CNT_WIDTH-1:0] LastRound = CNT_WIDTH'(ROUNDS - 1);
   localparam logic [CNT_WIDTH-1:0] CntOne    = CNT_WIDTH'(1);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 new_q, new_d;
   logic                 last_q, last_d;
   logic                 block_done_q, block_done_d;

   // State, index, message flags and the block-done pulse register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         count_q      <= '0;
         new_q        <= 1'b0;
         last_q       <= 1'b0;
         block_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         new_q        <= new_d;
         last_q       <= last_d;
         block_done_q <= block_done_d;
      end
   end

   // Next-state and index sequencing; clear_in overrides every transition.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      new_d        = new_q;
      last_d       = last_q;
      block_done_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_in) begin
               new_d   = new_msg_in;
               last_d  = last_blk_in;
               count_d = '0;
               state_d = new_msg_in ? StInit : StLoad;
            end
         end
         StInit: state_d = StLoad;
         StLoad: begin
            // ready is always high in LOAD, so valid alone is the handshake
            if (msg_valid_in) begin
               if (count_q == LastWord) begin
                  count_d = '0;
                  state_d = StRound;
               end else begin
                  count_d = count_q + CntOne;
               end
            end
         end
         StRound: begin
            if (count_q == LastRound) begin
               count_d = '0;
               state_d = StUpdate;
            end else begin
               count_d = count_q + CntOne;
            end
         end
         StUpdate: begin
            count_d = '0;
            if (last_q) begin
               state_d = StDone;
            end else begin
               state_d      = StIdle;
               block_done_d = 1'b1;
            end
         end
         StDone: begin
            if (digest_ready_in) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (clear_in) begin
         state_d      = StIdle;
         count_d      = '0;
         new_d        = 1'b0;
         last_d       = 1'b0;
         block_done_d = 1'b0;
      end
   end

   // Datapath controls decoded from the registered state.
   always_comb begin
      fsm_state_out    = state_q;
      count_out        = count_q;
      msg_ready_out    = (state_q == StLoad);
      word_out         = (state_q == StLoad) ? msg_word_in : '0;
      // INIT is only ever entered with new_q set
      hash_init_out    = (state_q == StInit) && new_q;
      round_en_out     = (state_q == StRound);
      hash_update_out  = (state_q == StUpdate);
      block_done_out   = block_done_q;
      digest_valid_out = (state_q == StDone);
      busy_out         = (state_q != StIdle);
   end

endmodule

// File: tb/tb_sha256_core_ctrl.sv
// Self-checking bench for sha256_core_ctrl: per-cycle comparison against a
// schedule derived from the block-sequencing rules.
module tb_sha256_core_ctrl;

   localparam int DW = 32;
   localparam int CW = 7;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_INIT   = 3'd1;
   localparam logic [2:0] S_LOAD   = 3'd2;
   localparam logic [2:0] S_ROUND  = 3'd3;
   localparam logic [2:0] S_UPDATE = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_in = 1'b0;
   logic          new_msg_in = 1'b0;
   logic          last_blk_in = 1'b0;
   logic          clear_in = 1'b0;
   logic          msg_valid_in = 1'b0;
   logic [DW-1:0] msg_word_in = '0;
   logic          msg_ready_out;
   logic [2:0]    fsm_state_out;
   logic [CW-1:0] count_out;
   logic [DW-1:0] word_out;
   logic          hash_init_out;
   logic          round_en_out;
   logic          hash_update_out;
   logic          block_done_out;
   logic          digest_valid_out;
   logic          digest_ready_in = 1'b0;
   logic          busy_out;

   int n_checks = 0;
   int n_pass   = 0;
   bit vpat[256];

   sha256_core_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_in         (start_in),
      .new_msg_in       (new_msg_in),
      .last_blk_in      (last_blk_in),
      .clear_in         (clear_in),
      .msg_valid_in     (msg_valid_in),
      .msg_word_in      (msg_word_in),
      .msg_ready_out    (msg_ready_out),
      .fsm_state_out    (fsm_state_out),
      .count_out        (count_out),
      .word_out         (word_out),
      .hash_init_out    (hash_init_out),
      .round_en_out     (round_en_out),
      .hash_update_out  (hash_update_out),
      .block_done_out   (block_done_out),
      .digest_valid_out (digest_valid_out),
      .digest_ready_in  (digest_ready_in),
      .busy_out         (busy_out)
   );

   always #5 clk = ~clk;

   function automatic logic [48:0] observed();
      return {fsm_state_out, count_out, msg_ready_out, word_out, hash_init_out, round_en_out,
              hash_update_out, block_done_out, digest_valid_out, busy_out};
   endfunction

   task automatic fill_all_valid();
      for (int i = 0; i < 256; i++) vpat[i] = 1'b1;
   endtask

   // Runs one block from IDLE. Expected behaviour comes from an event schedule:
   // INIT slot, the 16 handshake cycles, 64 rounds, update, then DONE/IDLE.
   task automatic run_block(input string name, input bit nw, input bit lst, input int rdy_delay,
                            input int clear_at);
      int load_start, round_start, upd, done_end, end_cyc, total, k;
      int hs_cyc[16];
      load_start = nw ? 2 : 1;
      k = 0;
      for (int i = 0; i < 256 && k < 16; i++) begin
         if (vpat[i]) begin
            hs_cyc[k] = load_start + i;
            k++;
         end
      end
      round_start = hs_cyc[15] + 1;
      upd         = round_start + 64;
      done_end    = upd + 1 + rdy_delay;
      end_cyc     = lst ? done_end + 1 : upd + 1;
      total       = end_cyc + 2;
      if (clear_at >= 0 && clear_at + 3 < total) total = clear_at + 3;
      for (int c = 0; c < total; c++) begin
         logic [2:0]    es;
         logic [CW-1:0] ec;
         logic [DW-1:0] w;
         logic [48:0]   exp_v, got;
         bit            bd;
         int            nh;
         if (clear_at >= 0 && c > clear_at) es = S_IDLE;
         else if (c == 0)                   es = S_IDLE;
         else if (c < load_start)           es = S_INIT;
         else if (c < round_start)          es = S_LOAD;
         else if (c < upd)                  es = S_ROUND;
         else if (c == upd)                 es = S_UPDATE;
         else if (lst && c <= done_end)     es = S_DONE;
         else                               es = S_IDLE;
         ec = '0;
         if (es == S_LOAD) begin
            nh = 0;
            for (int j = 0; j < 16; j++) if (hs_cyc[j] < c) nh++;
            ec = CW'(nh);
         end else if (es == S_ROUND) begin
            ec = CW'(c - round_start);
         end
         bd = !lst && (c == upd + 1) && !(clear_at >= 0 && clear_at <= upd);
         @(posedge clk);
         #1;
         start_in        = (c == 0) || (es != S_IDLE && $urandom_range(3) == 0);
         new_msg_in      = (c == 0) ? nw : 1'($urandom_range(1));
         last_blk_in     = (c == 0) ? lst : 1'($urandom_range(1));
         clear_in        = (c == clear_at);
         msg_valid_in    = (es == S_LOAD) ? vpat[c - load_start] : 1'($urandom_range(1));
         w               = $urandom;
         msg_word_in     = w;
         digest_ready_in = (es == S_DONE) ? (c == done_end) : 1'($urandom_range(1));
         @(negedge clk);
         exp_v = {es, ec, es == S_LOAD, (es == S_LOAD) ? w : 32'h0, es == S_INIT,
                  es == S_ROUND, es == S_UPDATE, bd, es == S_DONE, es != S_IDLE};
         got = observed();
         n_checks++;
         if (got !== exp_v)
            $display("FAIL %s cyc=%0d got=%h exp=%h (state %0d want %0d, count %0d want %0d)",
                     name, c, got, exp_v, fsm_state_out, es, count_out, ec);
         else
            n_pass++;
      end
      @(posedge clk);
      #1;
      start_in     = 1'b0;
      clear_in     = 1'b0;
      msg_valid_in = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if (observed() !== 49'h0) $display("FAIL reset_init got=%h exp=0", observed());
      else n_pass++;
      rst_n = 1'b1;
      // Start a block and stream words back-to-back until round 30.
      @(posedge clk);
      #1;
      start_in     = 1'b1;
      new_msg_in   = 1'b1;
      last_blk_in  = 1'b1;
      msg_valid_in = 1'b1;
      @(posedge clk);
      #1;
      start_in = 1'b0;
      repeat (47) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (fsm_state_out !== S_ROUND || count_out !== 7'd30)
         $display("FAIL reset_pre state=%0d count=%0d exp state=3 count=30",
                  fsm_state_out, count_out);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (observed() !== 49'h0) $display("FAIL reset_mid got=%h exp=0", observed());
      else n_pass++;
      @(negedge clk);
      msg_valid_in = 1'b0;
      rst_n        = 1'b1;
      n_checks++;
      if (busy_out !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_out);
      else n_pass++;
   endtask

   task automatic test_single_block();
      fill_all_valid();
      run_block("single_block", 1'b1, 1'b1, 0, -1);
   endtask

   task automatic test_stalled_load();
      fill_all_valid();
      vpat[7] = 1'b0;
      vpat[8] = 1'b0;
      vpat[9] = 1'b0;
      run_block("stalled_load", 1'b1, 1'b1, 0, -1);
   endtask

   task automatic test_two_block();
      fill_all_valid();
      run_block("two_block_1", 1'b1, 1'b0, 0, -1);
      for (int i = 0; i < 256; i++) vpat[i] = (i >= 100) || ($urandom_range(99) >= 30);
      run_block("two_block_2", 1'b0, 1'b1, 0, -1);
   endtask

   task automatic test_backpressure();
      fill_all_valid();
      run_block("backpressure", 1'b1, 1'b1, 5, -1);
   endtask

   task automatic test_abort();
      fill_all_valid();
      // Rounds start at cycle 18, so cycle 58 is round 40.
      run_block("abort", 1'b1, 1'b1, 0, 58);
      run_block("after_abort", 1'b1, 1'b0, 0, -1);
      run_block("start_with_clear", 1'b1, 1'b1, 0, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         int pct, clr;
         pct = $urandom_range(50);
         for (int i = 0; i < 256; i++) vpat[i] = (i >= 100) || ($urandom_range(99) >= pct);
         clr = ($urandom_range(3) == 0) ? int'($urandom_range(100)) : -1;
         run_block("random", 1'($urandom_range(1)), 1'($urandom_range(1)),
                   int'($urandom_range(6)), clr);
      end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_stalled_load();
      test_two_block();
      test_backpressure();
      test_abort();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
